hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control unit for the five-stage core. It is the producer end of the bubble/stall protocol that the stage registers consume.
- Detects load-use hazards, EX-stage branch/jump redirects and data-memory wait states.
- Drives hold and invalid (bubble-insert) to PC, IF/ID, ID/EX and EX/MEM.
- Keeps saturating stall and flush performance counters.

Parameters:
- FLUSH_CYCLES, 1, extra cycles of ifid_invalid after the redirect cycle, covering synchronous imem latency; legal range 0..7.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- sys_clk  input  1  clock; all state updates on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- id_rs1  input  5  rs1 index of the instruction in ID.
- id_rs2  input  5  rs2 index of the instruction in ID.
- id_uses_rs1  input  1  ID instruction reads rs1.
- id_uses_rs2  input  1  ID instruction reads rs2.
- ex_rd  input  5  destination of the instruction in EX.
- ex_is_write_rf  input  1  EX instruction writes the register file.
- ex_is_load  input  1  EX instruction is a load (wb_select = memory).
- ex_redirect  input  1  taken branch or jump resolved in EX.
- mem_req  input  1  MEM stage has an outstanding dmem access.
- mem_ack  input  1  dmem access completes this cycle.
- pc_hold  output  1  PC keeps its value.
- ifid_hold  output  1  IF/ID keeps its contents.
- ifid_invalid  output  1  IF/ID loads a bubble.
- idex_hold  output  1  ID/EX keeps its contents.
- idex_invalid  output  1  ID/EX loads a bubble (drives the ID/EX invalid input).
- exmem_hold  output  1  EX/MEM keeps its contents.
- stall_cnt  output  CNT_WIDTH  count of cycles with pc_hold = 1.
- flush_cnt  output  CNT_WIDTH  count of redirect events.

Behaviour:
- Interface (already decided): one clock, sys_clk; reset sys_rst is synchronous and active-high.
- Outputs are combinational from the registered state plus the current inputs, so they act in the same cycle. Counters and state are registered.
- Reset (cycle with sys_rst = 1, including mid-operation):
  - state becomes RUN; flush counter becomes 0; stall_cnt and flush_cnt become 0.
  - Outputs during reset: ifid_invalid = 1 and idex_invalid = 1; pc_hold, ifid_hold, idex_hold and exmem_hold = 0.
- States: RUN, FLUSH (substate counter fcnt, 3 bits).
- Derived terms:
  - memwait = mem_req & ~mem_ack.
  - lu = ex_is_load & ex_is_write_rf & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Priority within a cycle, highest first: reset > memwait > ex_redirect > FLUSH bubble > lu > run.
- memwait:
  - All four holds = 1; both invalids = 0; state and fcnt frozen.
  - A pending ex_redirect stays asserted by the frozen EX stage and is acted on in the first unfrozen cycle.
- ex_redirect (no memwait):
  - ifid_invalid = 1, idex_invalid = 1, holds = 0; flush_cnt increments.
  - If FLUSH_CYCLES > 0: state goes to FLUSH with fcnt = FLUSH_CYCLES; otherwise state stays RUN.
  - lu is ignored because the ID instruction is wrong-path.
  - A redirect arriving while already in FLUSH restarts fcnt.
- FLUSH (no memwait, no redirect):
  - ifid_invalid = 1; idex_invalid = 0; holds = 0; lu is suppressed.
  - fcnt decrements each cycle; at fcnt == 1 the next state is RUN.
- lu in RUN:
  - pc_hold = 1, ifid_hold = 1, idex_invalid = 1; others 0.
  - The load advances to MEM, so lu clears the following cycle: exactly one bubble.
- Run: all outputs 0.
- Register x0 never creates a hazard.
- Counters: stall_cnt increments on every non-reset cycle with pc_hold = 1. Both counters saturate at all-ones and never wrap.
- ifid_hold and ifid_invalid are never both 1. The same holds for idex_hold and idex_invalid.

Decomposition:
- Shared package/include `para.v`: state encodings (HC_RUN, HC_FLUSH), register-index width (5), default FLUSH_CYCLES.
- One natural sub-module: sat_counter (CNT_WIDTH, inc, sync reset), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset for 3 cycles mid-FLUSH -> during reset ifid_invalid = idex_invalid = 1 and holds = 0; after release state = RUN, counters = 0, all outputs 0.
- EX load writing ex_rd = 5, ID uses rs2 = 5 -> exactly 1 cycle of pc_hold/ifid_hold/idex_invalid = 1, then 0; stall_cnt = 1. Same stimulus with ex_rd = 0 -> no stall.
- ex_redirect pulse with FLUSH_CYCLES = 1 -> cycle t: ifid_invalid = idex_invalid = 1; cycle t+1: ifid_invalid = 1 only; cycle t+2: all 0; flush_cnt = 1.
- mem_req = 1 with mem_ack held 0 for 4 cycles while ex_redirect = 1 -> 4 cycles with all holds = 1 and no invalids; flush occurs in the ack cycle; stall_cnt = 4.
- Load-use and ex_redirect in the same cycle -> redirect behaviour only; stall_cnt unchanged.
- Preload stall_cnt near all-ones (CNT_WIDTH = 4, 20 stall cycles) -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// state encodings, register-index width and the default flush length.
package hazard_ctrl_pkg;

   localparam int REG_IDX_W            = 5;
   localparam int FCNT_W               = 3;
   localparam int DEFAULT_FLUSH_CYCLES = 1;

   typedef enum logic [0:0] {
      HC_RUN   = 1'b0,
      HC_FLUSH = 1'b1
   } hc_state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Holds at all-ones once reached; never wraps back to zero.
module sat_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   // NOTE: sequential state always uses non-blocking assignment so that every
   // flop samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX redirect flushes and dmem
// wait-state freezes, driving hold/bubble controls plus performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_is_write_rf,
   input  logic                 ex_is_load,
   input  logic                 ex_redirect,
   input  logic                 mem_req,
   input  logic                 mem_ack,
   output logic                 pc_hold,
   output logic                 ifid_hold,
   output logic                 ifid_invalid,
   output logic                 idex_hold,
   output logic                 idex_invalid,
   output logic                 exmem_hold,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_CYCLES);

   hc_state_e         state;
   logic [FCNT_W-1:0] fcnt;

   logic memwait;
   logic lu;
   logic redirect_go;

   assign memwait = mem_req & ~mem_ack;

   // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
   assign lu = ex_is_load & ex_is_write_rf & (ex_rd != '0) &
               ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                (id_uses_rs2 & (id_rs2 == ex_rd)));

   // A redirect seen during a dmem wait is held by the frozen EX stage and
   // only takes effect once the pipeline moves again.
   assign redirect_go = ex_redirect & ~memwait & ~sys_rst;

   // NOTE: every output gets a default before the priority chain so no path
   // leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      pc_hold      = 1'b0;
      ifid_hold    = 1'b0;
      ifid_invalid = 1'b0;
      idex_hold    = 1'b0;
      idex_invalid = 1'b0;
      exmem_hold   = 1'b0;
      if (sys_rst) begin
         ifid_invalid = 1'b1;
         idex_invalid = 1'b1;
      end else if (memwait) begin
         pc_hold    = 1'b1;
         ifid_hold  = 1'b1;
         idex_hold  = 1'b1;
         exmem_hold = 1'b1;
      end else if (ex_redirect) begin
         ifid_invalid = 1'b1;
         idex_invalid = 1'b1;
      end else if (state == HC_FLUSH) begin
         ifid_invalid = 1'b1;
      end else if (lu) begin
         pc_hold      = 1'b1;
         ifid_hold    = 1'b1;
         idex_invalid = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= HC_RUN;
         fcnt  <= '0;
      end else if (memwait) begin
         state <= state;
         fcnt  <= fcnt;
      end else if (ex_redirect) begin
         if (FLUSH_CYCLES > 0) begin
            state <= HC_FLUSH;
            fcnt  <= FLUSH_INIT;
         end else begin
            state <= HC_RUN;
            fcnt  <= '0;
         end
      end else if (state == HC_FLUSH) begin
         if (fcnt == FCNT_W'(1)) begin
            state <= HC_RUN;
            fcnt  <= '0;
         end else begin
            fcnt <= fcnt - FCNT_W'(1);
         end
      end
   end

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .inc   (pc_hold),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .inc   (redirect_go),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (FLUSH_CYCLES = 1, 4-bit
// counters so saturation is reachable in a few cycles).
module tb_hazard_ctrl;

   localparam int CW = 4;

   // Output bundle order: pc_hold, ifid_hold, ifid_invalid, idex_hold, idex_invalid, exmem_hold
   localparam logic [5:0] O_RUN   = 6'b000000;
   localparam logic [5:0] O_RST   = 6'b001010;
   localparam logic [5:0] O_LU    = 6'b110010;
   localparam logic [5:0] O_REDIR = 6'b001010;
   localparam logic [5:0] O_FLUSH = 6'b001000;
   localparam logic [5:0] O_WAIT  = 6'b110101;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          id_uses_rs1, id_uses_rs2;
   logic          ex_is_write_rf, ex_is_load, ex_redirect;
   logic          mem_req, mem_ack;
   logic          pc_hold, ifid_hold, ifid_invalid;
   logic          idex_hold, idex_invalid, exmem_hold;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [5:0]    outs;

   int compared   = 0;
   int mismatched = 0;

   assign outs = {pc_hold, ifid_hold, ifid_invalid, idex_hold, idex_invalid, exmem_hold};

   hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(CW)) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_uses_rs1    (id_uses_rs1),
      .id_uses_rs2    (id_uses_rs2),
      .ex_rd          (ex_rd),
      .ex_is_write_rf (ex_is_write_rf),
      .ex_is_load     (ex_is_load),
      .ex_redirect    (ex_redirect),
      .mem_req        (mem_req),
      .mem_ack        (mem_ack),
      .pc_hold        (pc_hold),
      .ifid_hold      (ifid_hold),
      .ifid_invalid   (ifid_invalid),
      .idex_hold      (idex_hold),
      .idex_invalid   (idex_invalid),
      .exmem_hold     (exmem_hold),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   // Advance past the next rising edge; inputs are then changed and outputs
   // sampled mid-cycle, well away from either edge.
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_is_write_rf = 0; ex_is_load = 0; ex_redirect = 0;
      mem_req = 0; mem_ack = 0;
   endtask

   task automatic load_use_rs2(input logic [4:0] rd);
      ex_is_load = 1; ex_is_write_rf = 1; ex_rd = rd;
      id_uses_rs2 = 1; id_rs2 = rd;
   endtask

   task automatic do_reset();
      idle();
      sys_rst = 1;
      step();
      sys_rst = 0;
   endtask

   task automatic test_reset();
      idle();
      sys_rst = 1;
      #1;
      compared++;
      if (outs !== O_RST) begin
         $display("FAIL reset_outs_initial: got %b want %b", outs, O_RST); mismatched++;
      end
      step();
      sys_rst = 0;
      ex_redirect = 1;
      step();
      ex_redirect = 0;
      #1;
      compared++;
      if (outs !== O_FLUSH) begin
         $display("FAIL reset_pre_flush: got %b want %b", outs, O_FLUSH); mismatched++;
      end
      sys_rst = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         compared++;
         if (outs !== O_RST) begin
            $display("FAIL reset_mid_flush_outs[%0d]: got %b want %b", i, outs, O_RST); mismatched++;
         end
         step();
      end
      sys_rst = 0;
      #1;
      compared++;
      if (outs !== O_RUN || stall_cnt !== 0 || flush_cnt !== 0) begin
         $display("FAIL reset_release: outs %b stall %0d flush %0d want %b 0 0",
                  outs, stall_cnt, flush_cnt, O_RUN); mismatched++;
      end
   endtask

   task automatic test_load_use();
      do_reset();
      load_use_rs2(5'd5);
      #1;
      compared++;
      if (outs !== O_LU) begin
         $display("FAIL lu_rs2_stall: got %b want %b", outs, O_LU); mismatched++;
      end
      step();
      idle();
      #1;
      compared++;
      if (outs !== O_RUN) begin
         $display("FAIL lu_single_bubble: got %b want %b", outs, O_RUN); mismatched++;
      end
      step();
      compared++;
      if (stall_cnt !== 1) begin
         $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); mismatched++;
      end
      load_use_rs2(5'd0);
      #1;
      compared++;
      if (outs !== O_RUN) begin
         $display("FAIL lu_x0: got %b want %b", outs, O_RUN); mismatched++;
      end
      idle();
      ex_is_load = 1; ex_is_write_rf = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1;
      #1;
      compared++;
      if (outs !== O_LU) begin
         $display("FAIL lu_rs1_stall: got %b want %b", outs, O_LU); mismatched++;
      end
      id_uses_rs1 = 0;
      #1;
      compared++;
      if (outs !== O_RUN) begin
         $display("FAIL lu_rs1_unused: got %b want %b", outs, O_RUN); mismatched++;
      end
      id_uses_rs1 = 1; ex_is_write_rf = 0;
      #1;
      compared++;
      if (outs !== O_RUN) begin
         $display("FAIL lu_no_rf_write: got %b want %b", outs, O_RUN); mismatched++;
      end
      idle();
      step();
      compared++;
      if (stall_cnt !== 1) begin
         $display("FAIL lu_stall_cnt_after_x0: got %0d want 1", stall_cnt); mismatched++;
      end
   endtask

   task automatic test_redirect();
      do_reset();
      ex_redirect = 1;
      #1;
      compared++;
      if (outs !== O_REDIR) begin
         $display("FAIL redir_t0: got %b want %b", outs, O_REDIR); mismatched++;
      end
      step();
      ex_redirect = 0;
      load_use_rs2(5'd9);
      #1;
      compared++;
      if (outs !== O_FLUSH) begin
         $display("FAIL redir_t1_flush_lu_suppressed: got %b want %b", outs, O_FLUSH); mismatched++;
      end
      step();
      idle();
      #1;
      compared++;
      if (outs !== O_RUN || flush_cnt !== 1 || stall_cnt !== 0) begin
         $display("FAIL redir_t2: outs %b flush %0d stall %0d want %b 1 0",
                  outs, flush_cnt, stall_cnt, O_RUN); mismatched++;
      end
   endtask

   task automatic test_memwait();
      do_reset();
      mem_req = 1; mem_ack = 0; ex_redirect = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         compared++;
         if (outs !== O_WAIT) begin
            $display("FAIL memwait_hold[%0d]: got %b want %b", i, outs, O_WAIT); mismatched++;
         end
         step();
      end
      mem_ack = 1;
      #1;
      compared++;
      if (outs !== O_REDIR || flush_cnt !== 0) begin
         $display("FAIL memwait_ack_redirect: outs %b flush %0d want %b 0",
                  outs, flush_cnt, O_REDIR); mismatched++;
      end
      step();
      idle();
      #1;
      compared++;
      if (outs !== O_FLUSH || stall_cnt !== 4 || flush_cnt !== 1) begin
         $display("FAIL memwait_after: outs %b stall %0d flush %0d want %b 4 1",
                  outs, stall_cnt, flush_cnt, O_FLUSH); mismatched++;
      end
      // A wait during FLUSH freezes the bubble countdown.
      mem_req = 1;
      step();
      step();
      mem_req = 0;
      #1;
      compared++;
      if (outs !== O_FLUSH) begin
         $display("FAIL memwait_freezes_flush: got %b want %b", outs, O_FLUSH); mismatched++;
      end
      step();
      compared++;
      if (outs !== O_RUN || stall_cnt !== 6) begin
         $display("FAIL memwait_flush_done: outs %b stall %0d want %b 6",
                  outs, stall_cnt, O_RUN); mismatched++;
      end
   endtask

   task automatic test_lu_and_redirect();
      do_reset();
      load_use_rs2(5'd3);
      ex_redirect = 1;
      #1;
      compared++;
      if (outs !== O_REDIR) begin
         $display("FAIL lu_redir_outs: got %b want %b", outs, O_REDIR); mismatched++;
      end
      step();
      idle();
      step();
      compared++;
      if (stall_cnt !== 0 || flush_cnt !== 1) begin
         $display("FAIL lu_redir_counts: stall %0d flush %0d want 0 1", stall_cnt, flush_cnt); mismatched++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ex_redirect = 1;
      step();
      #1;
      compared++;
      if (outs !== O_REDIR) begin
         $display("FAIL b2b_second_redirect: got %b want %b", outs, O_REDIR); mismatched++;
      end
      step();
      ex_redirect = 0;
      #1;
      compared++;
      if (outs !== O_FLUSH) begin
         $display("FAIL b2b_flush_restarted: got %b want %b", outs, O_FLUSH); mismatched++;
      end
      step();
      compared++;
      if (outs !== O_RUN || flush_cnt !== 2) begin
         $display("FAIL b2b_done: outs %b flush %0d want %b 2", outs, flush_cnt, O_RUN); mismatched++;
      end
   endtask

   task automatic test_saturation();
      do_reset();
      load_use_rs2(5'd12);
      for (int i = 0; i < 15; i++) step();
      compared++;
      if (stall_cnt !== 15) begin
         $display("FAIL sat_reach_max: got %0d want 15", stall_cnt); mismatched++;
      end
      for (int i = 0; i < 5; i++) step();
      compared++;
      if (stall_cnt !== 15) begin
         $display("FAIL sat_no_wrap: got %0d want 15", stall_cnt); mismatched++;
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_memwait();
      test_lu_and_redirect();
      test_back_to_back();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
